// File: rtl/datapath_pkg.sv
// Shared scalar datapath types: FU count, source tag type and the per-FU issue life cycle.
package datapath_pkg;

  localparam int NUM_SCALAR_FU = 3;
  localparam int SCALAR_TAG_W  = 2;

  typedef logic [SCALAR_TAG_W-1:0] s_tag_t;

  typedef enum logic [1:0] {
    FU_IDLE  = 2'd0,
    FU_ISSUE = 2'd1,
    FU_EXEC  = 2'd2
  } fust_issue_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant to the first requester at or after ptr.
module rr_arbiter #(
  parameter int N  = 3,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic          valid
);

  always_comb begin
    int j;
    logic [PW-1:0] idx;
    gnt   = '0;
    valid = 1'b0;
    j     = 0;
    idx   = '0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      idx = PW'(j);
      if (!valid && req[idx]) begin
        gnt[idx] = 1'b1;
        valid    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fust_s_issue_ctrl.sv
// Scalar FUST issue scheduler: picks one ready row per cycle round-robin, drives the
// issue port and tracks each FU through IDLE -> ISSUE -> EXEC.
module fust_s_issue_ctrl
  import datapath_pkg::*;
#(
  parameter int NUM_FU = NUM_SCALAR_FU,
  parameter int TAG_W  = SCALAR_TAG_W,
  parameter int IW     = (NUM_FU > 1) ? $clog2(NUM_FU) : 1
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic                          flush,
  input  logic [NUM_FU-1:0]             row_valid,
  input  logic [NUM_FU-1:0][TAG_W-1:0]  t1,
  input  logic [NUM_FU-1:0][TAG_W-1:0]  t2,
  input  logic                          wb_valid,
  input  logic [TAG_W-1:0]              wb_tag,
  input  logic [NUM_FU-1:0]             fu_ready,
  input  logic [NUM_FU-1:0]             fu_done,
  output logic                          issue_valid,
  output logic [NUM_FU-1:0]             issue_fu,
  output logic [IW-1:0]                 issue_idx,
  output logic [NUM_FU-1:0]             busy
);

  fust_issue_state_t state_q [NUM_FU];
  fust_issue_state_t state_d [NUM_FU];
  logic [IW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [NUM_FU-1:0] elig, gnt;
  logic              gvalid, port_free, take;
  logic [IW-1:0]     gidx;

  // Same-cycle writeback bypass; tag 0 means "no producer" and never matches a broadcast.
  function automatic logic rdy(input logic [TAG_W-1:0] t, input logic wv,
                               input logic [TAG_W-1:0] wt);
    return (t == '0) || (wv && (wt != '0) && (wt == t));
  endfunction

  always_comb begin
    port_free = 1'b1;
    elig      = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      elig[i] = row_valid[i] && (state_q[i] == FU_IDLE) &&
                rdy(t1[i], wb_valid, wb_tag) && rdy(t2[i], wb_valid, wb_tag);
      if (state_q[i] == FU_ISSUE && !fu_ready[i]) port_free = 1'b0;
    end
  end

  rr_arbiter #(.N(NUM_FU), .PW(IW)) u_arb (
    .req   (elig),
    .ptr   (rr_ptr_q),
    .gnt   (gnt),
    .valid (gvalid)
  );

  assign take = port_free && gvalid && !flush;

  always_comb begin
    gidx = '0;
    for (int i = 0; i < NUM_FU; i++)
      if (gnt[i]) gidx = IW'(i);
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (flush)     rr_ptr_d = '0;
    else if (take) rr_ptr_d = (gidx == IW'(NUM_FU - 1)) ? '0 : gidx + 1'b1;
    for (int i = 0; i < NUM_FU; i++) begin
      state_d[i] = state_q[i];
      if (flush) begin
        state_d[i] = FU_IDLE;
      end else begin
        unique case (state_q[i])
          FU_IDLE:  if (take && gnt[i]) state_d[i] = FU_ISSUE;
          FU_ISSUE: if (fu_ready[i])    state_d[i] = fu_done[i] ? FU_IDLE : FU_EXEC;
          FU_EXEC:  if (fu_done[i])     state_d[i] = FU_IDLE;
          default:                      state_d[i] = FU_IDLE;
        endcase
      end
    end
  end

  // Outputs are registered from next-state so they line up with the state register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < NUM_FU; i++) state_q[i] <= FU_IDLE;
      rr_ptr_q    <= '0;
      issue_valid <= 1'b0;
      issue_fu    <= '0;
      issue_idx   <= '0;
      busy        <= '0;
    end else begin
      for (int i = 0; i < NUM_FU; i++) state_q[i] <= state_d[i];
      rr_ptr_q    <= rr_ptr_d;
      issue_valid <= 1'b0;
      issue_fu    <= '0;
      issue_idx   <= '0;
      for (int i = 0; i < NUM_FU; i++) begin
        busy[i] <= (state_d[i] != FU_IDLE);
        if (state_d[i] == FU_ISSUE) begin
          issue_valid <= 1'b1;
          issue_fu[i] <= 1'b1;
          issue_idx   <= IW'(i);
        end
      end
    end
  end

endmodule

// File: tb/tb_fust_s_issue_ctrl.sv
// Directed bench for fust_s_issue_ctrl with hand-computed expectations.
module tb_fust_s_issue_ctrl;

  logic             CLK = 1'b0;
  logic             RST = 1'b1;
  logic             flush = 1'b0;
  logic [2:0]       row_valid = '0;
  logic [2:0][1:0]  t1 = '0;
  logic [2:0][1:0]  t2 = '0;
  logic             wb_valid = 1'b0;
  logic [1:0]       wb_tag = '0;
  logic [2:0]       fu_ready = '0;
  logic [2:0]       fu_done = '0;
  logic             issue_valid;
  logic [2:0]       issue_fu;
  logic [1:0]       issue_idx;
  logic [2:0]       busy;

  int errors = 0;
  int checks = 0;

  fust_s_issue_ctrl dut (
    .CLK(CLK), .RST(RST), .flush(flush), .row_valid(row_valid),
    .t1(t1), .t2(t2), .wb_valid(wb_valid), .wb_tag(wb_tag),
    .fu_ready(fu_ready), .fu_done(fu_done),
    .issue_valid(issue_valid), .issue_fu(issue_fu),
    .issue_idx(issue_idx), .busy(busy)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; inputs and checks happen 1 time unit after the rising edge.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic out(input string tag, input logic v, input logic [2:0] fu,
                     input logic [1:0] idx, input logic [2:0] b);
    chk({tag, ".valid"}, 32'(issue_valid), 32'(v));
    chk({tag, ".fu"},    32'(issue_fu),    32'(fu));
    chk({tag, ".idx"},   32'(issue_idx),   32'(idx));
    chk({tag, ".busy"},  32'(busy),        32'(b));
  endtask

  task automatic do_flush();
    flush = 1'b1; row_valid = '0; fu_ready = '0; fu_done = '0; wb_valid = 1'b0;
    step();
    flush = 1'b0;
  endtask

  initial begin
    #2;
    out("rst", 0, 3'b000, 0, 3'b000);
    step(); step();
    RST = 1'b0;
    step();

    // 1: FU1 into EXEC, then async reset mid-stream
    row_valid = 3'b010; fu_ready = 3'b010;
    step();
    out("t1.iss", 1, 3'b010, 1, 3'b010);
    row_valid = 3'b000;
    step();
    out("t1.exec", 0, 3'b000, 0, 3'b010);
    #2 RST = 1'b1;
    #1;
    out("t1.async", 0, 3'b000, 0, 3'b000);
    step();
    RST = 1'b0; fu_ready = '0;
    step(); step();
    out("t1.idle", 0, 3'b000, 0, 3'b000);

    // 2: round-robin over three ready rows
    row_valid = 3'b111; fu_ready = 3'b111;
    step(); out("t2.g0", 1, 3'b001, 0, 3'b001);
    step(); out("t2.g1", 1, 3'b010, 1, 3'b011);
    step(); out("t2.g2", 1, 3'b100, 2, 3'b111);
    step(); out("t2.full", 0, 3'b000, 0, 3'b111);
    fu_done = 3'b111;
    step(); out("t2.done", 0, 3'b000, 0, 3'b000);
    fu_done = 3'b000;
    step(); out("t2.wrap", 1, 3'b001, 0, 3'b001);
    do_flush();
    out("t2.flush", 0, 3'b000, 0, 3'b000);

    // 3: wakeup bypass; tag 0 broadcast never wakes
    row_valid = 3'b100; t1[2] = 2'd1;
    step(); out("t3.wait", 0, 3'b000, 0, 3'b000);
    wb_valid = 1'b1; wb_tag = 2'd1;
    step(); out("t3.wake", 1, 3'b100, 2, 3'b100);
    do_flush();
    row_valid = 3'b100; wb_valid = 1'b1; wb_tag = 2'd0;
    step(); out("t3.tag0", 0, 3'b000, 0, 3'b000);
    wb_valid = 1'b0; t1 = '0;
    do_flush();

    // 4: backpressure holds the port; FU1 waits
    row_valid = 3'b011;
    step(); out("t4.h1", 1, 3'b001, 0, 3'b001);
    step(); out("t4.h2", 1, 3'b001, 0, 3'b001);
    step(); out("t4.h3", 1, 3'b001, 0, 3'b001);
    fu_ready = 3'b001;
    step(); out("t4.next", 1, 3'b010, 1, 3'b011);

    // 5: single-cycle FU1 returns to IDLE and is regranted
    row_valid = 3'b010; fu_ready = 3'b010; fu_done = 3'b010;
    step(); out("t5.done", 0, 3'b000, 0, 3'b001);
    fu_ready = 3'b000; fu_done = 3'b000;
    step(); out("t5.regnt", 1, 3'b010, 1, 3'b011);
    do_flush();

    // 6: flush beats grant and done
    row_valid = 3'b001; fu_ready = 3'b001;
    step(); out("t6.s1", 1, 3'b001, 0, 3'b001);
    row_valid = 3'b100;
    step(); out("t6.s2", 1, 3'b100, 2, 3'b101);
    row_valid = 3'b010; fu_ready = 3'b000; fu_done = 3'b001; flush = 1'b1;
    step(); out("t6.flush", 0, 3'b000, 0, 3'b000);
    flush = 1'b0; fu_done = 3'b000;
    step(); out("t6.after", 1, 3'b010, 1, 3'b010);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
